// File: rtl/rv_pkg.sv
// Shared RV32 core types: fetch entry layout, fetch FSM encoding, small PC helpers.
// No logic of its own; latency not applicable.
// No flow control of its own; carries no state.
package rv_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned IMEM_AW_DEFAULT = 11;
    localparam logic [XLEN-1:0] RV_NOP      = 32'h0000_0013;

    // One fetched instruction as it travels from imem to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [1:0] {
        ST_RST        = 2'd0,
        ST_RUN        = 2'd1,
        ST_HOLD       = 2'd2,
        ST_HALT_FAULT = 2'd3
    } ifetch_state_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_skid_buf.sv
// 2-entry FIFO holding fetched entries that decode has not yet taken; flush empties it.
// Latency: pushed data visible at head the cycle after the push.
// Backpressure: push ignored when full without a same-cycle pop; caller sizes issue by free_o.
module ifetch_skid_buf #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_rdy_i,
    output logic [W-1:0] head_dat_o,
    output logic [1:0]   count_o,
    output logic [1:0]   free_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_rdy_i && (count_q != 2'd0);
    assign do_push = push_vld_i && ((count_q != 2'd2) || do_pop);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; flush discards everything buffered.
    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count_q gates whether a slot is meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign free_o     = 2'd2 - count_q;

endmodule

// File: rtl/ifetch_unit.sv
// RV32 fetch stage: owns the PC, reads the BSRAM, hands {pc, instr, fault} to decode (macro IFETCH_MISALIGN_TRAP_EN).
// Latency: first imem read 1 cycle after reset release, instruction offered the cycle after each read.
// Backpressure: reads issue only while buffer room exceeds reads in flight; outputs hold while !out_ready.
module ifetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_ce,
    output logic               imem_oce,
    output logic               imem_wre,
    output logic [IMEM_AW-1:0] imem_ad,
    input  logic [XLEN-1:0]    imem_dout,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_instr,
    output logic               out_fault
);

    ifetch_state_t   state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            infl_q, infl_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic            infl_fault_q, infl_fault_d;

    logic [XLEN-1:0] redir_tgt;
    logic            fetch_fault;

    fetch_entry_t    infl_ent;
    fetch_entry_t    head_ent;
    fetch_entry_t    sel_ent;
    logic [FETCH_ENTRY_W-1:0] head_raw;
    logic [1:0]      buf_cnt;
    logic [1:0]      buf_free;
    logic            buf_nonempty;
    logic            accept;
    logic            bypass;
    logic            buf_push;
    logic            buf_pop;
    logic [2:0]      room;
    logic            issue_ok;

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Misaligned targets are kept intact so the faulting PC reaches decode.
    assign redir_tgt   = redirect_pc;
    assign fetch_fault = is_misaligned(fetch_pc_q);
`else
    // Alignment bits are dropped; the fetch PC is always word aligned.
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^redirect_pc[1:0];
    assign redir_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
    assign fetch_fault      = 1'b0;
`endif

    // The in-flight read is tagged here; its data arrives on imem_dout this cycle.
    assign infl_ent     = '{pc: infl_pc_q, instr: imem_dout, fault: infl_fault_q};
    assign head_ent     = fetch_entry_t'(head_raw);
    assign buf_nonempty = (buf_cnt != 2'd0);

    // Buffered entries are older than the in-flight one, so they go first;
    // with an empty buffer the BSRAM data is offered straight through.
    assign out_valid = buf_nonempty || infl_q;
    assign sel_ent   = buf_nonempty ? head_ent : infl_ent;
    assign out_pc    = out_valid ? sel_ent.pc    : '0;
    assign out_instr = out_valid ? sel_ent.instr : '0;
    assign out_fault = out_valid & sel_ent.fault;

    assign accept   = out_valid && out_ready;
    assign buf_pop  = accept && buf_nonempty;
    assign bypass   = accept && !buf_nonempty;
    assign buf_push = infl_q && !bypass;

    // Counting this cycle's accept as a freed slot keeps back-to-back issue bubble-free.
    assign room     = {1'b0, buf_free} + {2'b00, accept};
    assign issue_ok = room > {2'b00, infl_q};

    assign imem_oce = 1'b1;
    assign imem_wre = 1'b0;
    assign imem_ad  = fetch_pc_q[IMEM_AW+1:2];

    ifetch_skid_buf #(
        .W (FETCH_ENTRY_W)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_i    (redirect_valid),
        .push_vld_i (buf_push),
        .push_dat_i (infl_ent),
        .pop_rdy_i  (buf_pop),
        .head_dat_o (head_raw),
        .count_o    (buf_cnt),
        .free_o     (buf_free)
    );

    // Next-state and issue decision; a redirect overrides issue and drops the in-flight read.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        infl_d       = 1'b0;
        infl_pc_d    = infl_pc_q;
        infl_fault_d = infl_fault_q;
        imem_ce      = 1'b0;
        if (redirect_valid) begin
            state_d    = ST_RUN;
            fetch_pc_d = redir_tgt;
        end else begin
            case (state_q)
                ST_RST: begin
                    state_d = ST_RUN;
                end
                ST_RUN, ST_HOLD: begin
                    if (issue_ok) begin
                        imem_ce      = 1'b1;
                        infl_d       = 1'b1;
                        infl_pc_d    = fetch_pc_q;
                        infl_fault_d = fetch_fault;
                        fetch_pc_d   = pc_next(fetch_pc_q);
                        state_d      = fetch_fault ? ST_HALT_FAULT : ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HALT_FAULT: begin
                    state_d = ST_HALT_FAULT;
                end
                default: begin
                    state_d = ST_RST;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_RST;
            fetch_pc_q   <= RESET_PC;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            infl_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            infl_fault_q <= infl_fault_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: per-cycle vector table plus a back-pressure stream run.
// Latency: not applicable.
// Backpressure: out_ready driven from the table, then from a pseudo-random pattern.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_ce;
    logic        imem_oce;
    logic        imem_wre;
    logic [10:0] imem_ad;
    logic [31:0] imem_dout = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (11)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_ce        (imem_ce),
        .imem_oce       (imem_oce),
        .imem_wre       (imem_wre),
        .imem_ad        (imem_ad),
        .imem_dout      (imem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    // Memory contents: word 0 is addi sp,x0,128; every other word encodes its index.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [10:0] w;
        w = pc[12:2];
        return (w == 11'd0) ? 32'h0800_0113 : {16'hC0DE, 5'd0, w};
    endfunction

    // BSRAM model: one-cycle synchronous read.
    always @(posedge clk) begin
        if (imem_ce) imem_dout <= word_at({19'd0, imem_ad, 2'b00});
    end

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ce;
        logic [10:0] ad;
        logic        vld;
        logic [31:0] pc;
        logic        flt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ce, input logic [10:0] ad, input logic vld,
                       input logic [31:0] pc, input logic flt);
        vec_t v;
        v.rst_n = rst_n; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ce = ce; v.ad = ad; v.vld = vld; v.pc = pc; v.flt = flt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic        hold_prev;
        int          n_acc;

        //   rst rv  rpc           rdy | ce ad      vld pc            flt
        // T1: reset release, ce at cycle 1, first instr at cycle 2, back-to-back.
        add(0, 0, 32'h0,       1,  0, 11'h0,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  0, 11'h0,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h0,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h1,   1, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h2,   1, 32'h4,     0);
        add(1, 0, 32'h0,       1,  1, 11'h3,   1, 32'h8,     0);
        add(1, 0, 32'h0,       1,  1, 11'h4,   1, 32'hC,     0);
        // T2: five cycles of back-pressure; output held, ce low once 2 outstanding.
        add(1, 0, 32'h0,       0,  1, 11'h5,   1, 32'h10,    0);
        add(1, 0, 32'h0,       0,  0, 11'h0,   1, 32'h10,    0);
        add(1, 0, 32'h0,       0,  0, 11'h0,   1, 32'h10,    0);
        add(1, 0, 32'h0,       0,  0, 11'h0,   1, 32'h10,    0);
        add(1, 0, 32'h0,       0,  0, 11'h0,   1, 32'h10,    0);
        add(1, 0, 32'h0,       1,  1, 11'h6,   1, 32'h10,    0);
        add(1, 0, 32'h0,       1,  1, 11'h7,   1, 32'h14,    0);
        add(1, 0, 32'h0,       1,  1, 11'h8,   1, 32'h18,    0);
        add(1, 0, 32'h0,       1,  1, 11'h9,   1, 32'h1C,    0);
        // T3: redirect with one buffered entry and one read in flight.
        add(1, 1, 32'h40,      0,  0, 11'h0,   1, 32'h20,    0);
        add(1, 0, 32'h0,       1,  1, 11'h10,  0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h11,  1, 32'h40,    0);
        add(1, 0, 32'h0,       1,  1, 11'h12,  1, 32'h44,    0);
        // T4: redirect in the same cycle as an accepted transfer.
        add(1, 1, 32'h100,     1,  0, 11'h0,   1, 32'h48,    0);
        add(1, 0, 32'h0,       1,  1, 11'h40,  0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h41,  1, 32'h100,   0);
        // T5: word address wraps past 2^11-1; full PC keeps counting.
        add(1, 1, 32'h1FF8,    1,  0, 11'h0,   1, 32'h104,   0);
        add(1, 0, 32'h0,       1,  1, 11'h7FE, 0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h7FF, 1, 32'h1FF8,  0);
        add(1, 0, 32'h0,       1,  1, 11'h0,   1, 32'h1FFC,  0);
        add(1, 0, 32'h0,       1,  1, 11'h1,   1, 32'h2000,  0);
        // T6: misaligned redirect target.
        add(1, 1, 32'h22,      1,  0, 11'h0,   1, 32'h2004,  0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        add(1, 0, 32'h0,       1,  1, 11'h8,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  0, 11'h0,   1, 32'h22,    1);
        add(1, 0, 32'h0,       1,  0, 11'h0,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  0, 11'h0,   0, 32'h0,     0);
        add(1, 1, 32'h80,      1,  0, 11'h0,   0, 32'h0,     0);
`else
        add(1, 0, 32'h0,       1,  1, 11'h8,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h9,   1, 32'h20,    0);
        add(1, 0, 32'h0,       1,  1, 11'hA,   1, 32'h24,    0);
        add(1, 0, 32'h0,       1,  1, 11'hB,   1, 32'h28,    0);
        add(1, 1, 32'h80,      1,  0, 11'h0,   1, 32'h2C,    0);
`endif
        add(1, 0, 32'h0,       1,  1, 11'h20,  0, 32'h0,     0);
        // Mid-operation reset: the read in flight must never surface.
        add(0, 0, 32'h0,       1,  1, 11'h21,  1, 32'h80,    0);
        add(1, 0, 32'h0,       1,  0, 11'h0,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h0,   0, 32'h0,     0);
        add(1, 0, 32'h0,       1,  1, 11'h1,   1, 32'h0,     0);

        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[r]) begin
            @(negedge clk);
            reset_n        = tbl[r].rst_n;
            redirect_valid = tbl[r].rv;
            redirect_pc    = tbl[r].rpc;
            out_ready      = tbl[r].rdy;
            #1;
            chk("imem_ce",   r, {31'd0, imem_ce},   {31'd0, tbl[r].ce});
            if (tbl[r].ce) chk("imem_ad", r, {21'd0, imem_ad}, {21'd0, tbl[r].ad});
            chk("out_valid", r, {31'd0, out_valid}, {31'd0, tbl[r].vld});
            chk("out_pc",    r, out_pc,             tbl[r].pc);
            chk("out_instr", r, out_instr,          tbl[r].vld ? word_at(tbl[r].pc) : 32'h0);
            chk("out_fault", r, {31'd0, out_fault}, {31'd0, tbl[r].flt});
            if (r == 0) begin
                chk("imem_oce", r, {31'd0, imem_oce}, 32'd1);
                chk("imem_wre", r, {31'd0, imem_wre}, 32'd0);
            end
        end

        // Stream run: irregular out_ready after a redirect; every accepted
        // instruction must follow on contiguously and stalled outputs must hold.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        out_ready      = 1'b1;
        exp_pc     = 32'h300;
        hold_prev  = 1'b0;
        prev_pc    = 32'h0;
        prev_instr = 32'h0;
        n_acc      = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            out_ready      = ($urandom_range(0, 2) != 0);
            #1;
            if (hold_prev) begin
                chk("hold_valid", 1000 + i, {31'd0, out_valid}, 32'd1);
                chk("hold_pc",    1000 + i, out_pc,    prev_pc);
                chk("hold_instr", 1000 + i, out_instr, prev_instr);
            end
            if (out_valid && out_ready) begin
                chk("stream_pc",    1000 + i, out_pc,    exp_pc);
                chk("stream_instr", 1000 + i, out_instr, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            hold_prev  = out_valid && !out_ready;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end
        chk("stream_progress", 2000, (n_acc >= 60) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
